// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and helpers for the hazard/stall sequencer and its MDU occupancy counter.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    StMduIdle = 1'b0,
    StMduBusy = 1'b1
  } mdu_state_e;

  typedef enum logic {
    MduOpMult = 1'b0,
    MduOpDiv  = 1'b1
  } mdu_op_e;

  // Countdown reload value: the unit stays busy for exactly the latency, ending on cnt==0.
  function automatic int unsigned mdu_reload(input logic op, input int unsigned mult_cycles,
                                             input int unsigned div_cycles);
    return ((op == MduOpDiv) ? div_cycles : mult_cycles) - 1;
  endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// Occupancy tracker for the multi-cycle multiply/divide unit: FSM, countdown and done pulse.
module mdu_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op,
  output logic busy,
  output logic last,
  output logic done
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StMduIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StMduIdle: begin
        if (start) begin
          state_d = StMduBusy;
          cnt_d   = CNT_W'(mdu_reload(op, MULT_CYCLES, DIV_CYCLES));
        end
      end
      StMduBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StMduIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StMduIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StMduBusy);
    last = (state_q == StMduBusy) && (cnt_q == '0);
    done = done_q;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-squash / MDU structural hazard control for the 5-stage pipeline.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IFIDRegRs,
  input  logic [4:0] IFIDRegRt,
  input  logic       IFIDUsesRt,
  input  logic       IDEXMemRead,
  input  logic [4:0] IDEXRegRt,
  input  logic       IDMduStart,
  input  logic       IDMduOp,
  input  logic       IDMduRead,
  input  logic       EXBranchTaken,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXFlush,
  output logic       MduBusy,
  output logic       MduDone
);

  logic mdu_busy, mdu_last, mdu_done;
  logic lu, sh, mdu_issue, mdu_hold;

  mdu_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mdu_busy_counter (
    .clk  (clk),
    .rst  (rst),
    .start(mdu_issue),
    .op   (IDMduOp),
    .busy (mdu_busy),
    .last (mdu_last),
    .done (mdu_done)
  );

  always_comb begin
    lu = IDEXMemRead && (IDEXRegRt != 5'd0) &&
         ((IDEXRegRt == IFIDRegRs) || (IFIDUsesRt && (IDEXRegRt == IFIDRegRt)));
    // The final busy cycle still holds the unit; the dependent op waits for the done cycle.
    mdu_hold  = mdu_busy || mdu_last;
    sh        = mdu_hold && (IDMduStart || IDMduRead);
    mdu_issue = !mdu_busy && IDMduStart && !EXBranchTaken && !lu && !rst;
  end

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    MduBusy   = mdu_busy && !rst;
    MduDone   = mdu_done;
    if (!rst) begin
      if (EXBranchTaken) begin
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
      end else if (sh || lu) begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IDEXFlush = 1'b1;
      end
    end
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage MIPS CPU. It sits beside the forwarding logic between IF/ID and ID/EX. It detects load-use hazards and squashes wrong-path instructions on taken branches. It also schedules a multi-cycle multiply/divide unit (MDU) and stalls ID while that unit is occupied.

Parameters:
MULT_CYCLES, 5, MDU latency for mult/multu in cycles (1..2^CNT_W)
DIV_CYCLES, 32, MDU latency for div/divu in cycles (1..2^CNT_W)
CNT_W, 6, width of the MDU countdown counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous, active-high
IFIDRegRs  in  5  rs field of the instruction in ID
IFIDRegRt  in  5  rt field of the instruction in ID
IFIDUsesRt  in  1  instruction in ID reads rt as a source
IDEXMemRead  in  1  instruction in EX is a load
IDEXRegRt  in  5  destination register of the load in EX
IDMduStart  in  1  instruction in ID is mult/multu/div/divu
IDMduOp  in  1  0 = mult class, 1 = div class
IDMduRead  in  1  instruction in ID is mfhi/mflo
EXBranchTaken  in  1  branch/jump resolved taken in EX
PCWrite  out  1  PC update enable
IFIDWrite  out  1  IF/ID register write enable
IFIDFlush  out  1  zero the IF/ID register
IDEXFlush  out  1  insert a bubble into ID/EX
MduBusy  out  1  MDU is occupied
MduDone  out  1  one-cycle pulse when the MDU result becomes valid

Behaviour:
- Registered state: FSM {MDU_IDLE, MDU_BUSY}, counter cnt[CNT_W-1:0], and MduDone. All other outputs are combinational from the state and the inputs.
- Reset (synchronous, rst=1 at the edge) forces state=MDU_IDLE, cnt=0, MduDone=0.
- Combinational outputs during reset and with no hazard: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXFlush=0, MduBusy=0.
- Load-use hazard (lu) is true when all of the following hold:
  - IDEXMemRead=1;
  - IDEXRegRt != 0;
  - IDEXRegRt == IFIDRegRs, or (IFIDUsesRt=1 and IDEXRegRt == IFIDRegRt).
- MDU structural hazard (sh) = (state==MDU_BUSY) and (IDMduStart or IDMduRead).
- Output priority, highest first:
  1. EXBranchTaken=1: IFIDFlush=1, IDEXFlush=1, PCWrite=1, IFIDWrite=1. Any stall is cancelled because the stalled ID instruction is squashed.
  2. sh=1: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0.
  3. lu=1: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0. The stall lasts exactly one cycle, since the load advances to MEM and lu clears.
- MDU issue condition: state==MDU_IDLE, IDMduStart=1, EXBranchTaken=0, and lu=0.
  - On issue the next state is MDU_BUSY.
  - cnt loads (IDMduOp ? DIV_CYCLES : MULT_CYCLES) - 1.
- In MDU_BUSY:
  - MduBusy=1.
  - While cnt != 0, cnt decrements by 1 per cycle.
  - When cnt==0, the next state is MDU_IDLE and MduDone=1 in the following cycle only.
  - The total time in BUSY equals the configured latency exactly. With latency 1, BUSY lasts one cycle.
- EXBranchTaken does not abort an MDU operation already in MDU_BUSY, because that operation is older than the branch.
- A start or mfhi/mflo arriving in the last BUSY cycle (cnt==0) still stalls. It issues or proceeds in the next cycle, when state is MDU_IDLE and MduDone=1.
- rst asserted during MDU_BUSY: the next edge returns to MDU_IDLE with cnt=0, and no MduDone pulse is generated.
- Register $0 never causes a load-use stall.

Decomposition:
- Add to ctrl_encode_def.v:
  - `MDU_IDLE = 1'b0, `MDU_BUSY = 1'b1;
  - `MDU_MULT = 1'b0, `MDU_DIV = 1'b1.
- One sub-module, mdu_busy_counter. It holds the FSM, cnt and the MduDone register, with inputs start, op and rst and outputs busy, last and done.
- hazard_stall_ctrl instantiates it and adds the combinational priority logic.

Test Plan:
1. lw $8 in EX (IDEXMemRead=1, IDEXRegRt=8); add $9,$8,$1 in ID (IFIDRegRs=8) -> exactly one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1, then all return to 1/1/0.
2. Load to $0, or IDEXRegRt=8 with IFIDRegRt=8 and IFIDUsesRt=0 -> no stall; PCWrite=1 throughout.
3. mult issued (IDMduOp=0, defaults) -> MduBusy high for exactly 5 cycles, MduDone pulses on the 6th; an mflo held in ID from cycle 2 stalls until MduDone, then proceeds.
4. div issued, then a second mult in ID the next cycle -> MduBusy high 32 cycles with the mult stalled; the mult issues the cycle MduDone=1 and MduBusy stays high for 5 more cycles.
5. EXBranchTaken=1 concurrent with lu=1 and IDMduStart=1 in IDLE -> IFIDFlush=1, IDEXFlush=1, PCWrite=1, and no MDU issue (MduBusy stays 0).
6. rst pulsed on the 10th cycle of a div -> next cycle MduBusy=0, MduDone never pulses, PCWrite=1, IFIDWrite=1, and both flushes are 0.
